// File: rtl/piso_pkg.sv
// Shared types and sizing helpers for the parallel-in serial-out transmitter.
package piso_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Bit counter width, kept at least one bit wide for tiny frames.
  function automatic int cnt_width(input int width);
    return ($clog2(width) < 1) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/piso_serializer.sv
// Framed parallel-in serial-out transmitter: one WIDTH-bit word per frame,
// one bit per clock, gapless back-to-back frames when din_valid is held.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             frame_start,
  output logic             frame_end
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_shreg;
  logic [WIDTH-1:0] w_shreg_nxt;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_cnt_nxt;
  logic             w_last;
  logic             w_accept;

  // Handshake: a word transfers on a rising edge where din_valid && din_ready.
  // din_ready depends only on registered state, so it is high in IDLE and
  // during the final bit of a frame, which lets the next word follow gaplessly.
  assign w_last    = (r_state == SHIFT) && (r_cnt == LAST_CNT);
  assign din_ready = (r_state == IDLE) || w_last;
  assign w_accept  = din_valid && din_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_shreg_nxt = r_shreg;
    w_cnt_nxt   = r_cnt;
    if (w_accept) begin
      w_state_nxt = SHIFT;
      w_shreg_nxt = din;
      w_cnt_nxt   = '0;
    end else if (r_state == SHIFT) begin
      if (w_last) begin
        w_state_nxt = IDLE;
      end else begin
        w_cnt_nxt = r_cnt + CW'(1);
        if (MSB_FIRST) begin
          w_shreg_nxt = {r_shreg[WIDTH-2:0], 1'b0};
        end else begin
          w_shreg_nxt = {1'b0, r_shreg[WIDTH-1:1]};
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_shreg <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_shreg <= w_shreg_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Outputs decode registers only; the shift register may hold stale bits in IDLE.
  assign sout_valid  = (r_state == SHIFT);
  assign sout        = sout_valid && (MSB_FIRST ? r_shreg[WIDTH-1] : r_shreg[0]);
  assign frame_start = sout_valid && (r_cnt == '0);
  assign frame_end   = w_last;

endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboard bench for piso_serializer: an MSB-first and an LSB-first instance
// share stimulus; a frame-level model predicts every serial bit and handshake.
module tb_piso_serializer;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] din;
  logic         din_valid;

  logic m_rdy, m_so, m_sv, m_fs, m_fe;
  logic l_rdy, l_so, l_sv, l_fs, l_fe;

  int vectors     = 0;
  int miscompares = 0;

  // Expected serial items: {sout, frame_start, frame_end}.
  logic [2:0] exp_q[$];
  logic [2:0] exp_lsb_q[$];
  int         bits_left = 0;

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
    .din_ready(m_rdy), .sout(m_so), .sout_valid(m_sv),
    .frame_start(m_fs), .frame_end(m_fe)
  );

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
    .din_ready(l_rdy), .sout(l_so), .sout_valid(l_sv),
    .frame_start(l_fs), .frame_end(l_fe)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // A frame occupies W output cycles; a new word is taken when nothing is
  // pending or only the final bit of the current frame remains.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      exp_lsb_q.delete();
      bits_left = 0;
    end else if (din_valid && (bits_left <= 1)) begin
      for (int i = 0; i < W; i++) begin
        exp_q.push_back({din[W-1-i], i == 0, i == W-1});
        exp_lsb_q.push_back({din[i], i == 0, i == W-1});
      end
      bits_left = W;
    end else if (bits_left > 0) begin
      bits_left = bits_left - 1;
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      logic [2:0] e;
      chk("msb_ready", 8'(m_rdy), 8'(bits_left <= 1));
      chk("lsb_ready", 8'(l_rdy), 8'(bits_left <= 1));
      chk("msb_valid", 8'(m_sv), 8'(bits_left > 0));
      chk("lsb_valid", 8'(l_sv), 8'(bits_left > 0));
      if (m_sv) begin
        if (exp_q.size() == 0) chk("msb_q_underflow", 8'(m_sv), 8'd0);
        else begin
          e = exp_q.pop_front();
          chk("msb_bit", 8'({m_so, m_fs, m_fe}), 8'(e));
        end
      end else begin
        chk("msb_idle_outs", 8'({m_so, m_fs, m_fe}), 8'd0);
      end
      if (l_sv) begin
        if (exp_lsb_q.size() == 0) chk("lsb_q_underflow", 8'(l_sv), 8'd0);
        else begin
          e = exp_lsb_q.pop_front();
          chk("lsb_bit", 8'({l_so, l_fs, l_fe}), 8'(e));
        end
      end else begin
        chk("lsb_idle_outs", 8'({l_so, l_fs, l_fe}), 8'd0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Present a word and hold it until the handshake edge; returns #1 after it
  // with din_valid still high so a caller can chain the next word gaplessly.
  task automatic send(input logic [W-1:0] w);
    int waited;
    din       = w;
    din_valid = 1'b1;
    waited    = 0;
    forever begin
      @(negedge clk);
      if (m_rdy) break;
      waited++;
      if (waited > 50) begin
        chk("send_timeout", 8'(m_rdy), 8'd1);
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    din_valid = 1'b0;
    din       = W'($urandom);
    repeat (n) begin
      @(posedge clk);
      #1;
      din = W'($urandom);
    end
  endtask

  task automatic check_reset_outs(input string tag);
    chk({tag, "_msb_outs"}, 8'({m_so, m_sv, m_fs, m_fe}), 8'd0);
    chk({tag, "_lsb_outs"}, 8'({l_so, l_sv, l_fs, l_fe}), 8'd0);
    chk({tag, "_ready"}, 8'({m_rdy, l_rdy}), 8'b11);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n     = 1'b0;
    din       = '0;
    din_valid = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_outs("reset");
    din_valid = 1'b0;
    rst_n     = 1'b1;

    // single word, then a gap
    @(posedge clk); #1;
    send(4'b0110);
    idle(6);

    // back-to-back frames with din_valid held
    send(4'b0011);
    send(4'b1100);
    idle(6);

    // request raised mid-frame is held off until the last bit
    send(4'b0101);
    din_valid = 1'b0;
    @(posedge clk); #1;
    send(4'b1010);
    idle(6);

    // asynchronous reset in the middle of a frame
    send(4'b0101);
    din_valid = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check_reset_outs("async_reset");
    repeat (2) @(posedge clk);
    #2;
    check_reset_outs("reset_hold");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    send(4'b1111);
    idle(6);

    // randomized words, gaps of 0..3 cycles
    for (int i = 0; i < 200; i++) begin
      send(W'($urandom));
      if ($urandom_range(0, 3) != 0) idle($urandom_range(1, 3));
    end
    idle(W + 2);

    chk("msb_queue_drained", 8'(exp_q.size()), 8'd0);
    chk("lsb_queue_drained", 8'(exp_lsb_q.size()), 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/piso_serializer.md
# piso_serializer

Parallel-in serial-out transmitter that converts WIDTH-bit parallel words into a framed serial bit stream, one bit per clock. It sits on the transmit side of the shift-register datapath and is the serial-producing counterpart to the parallel-register and serial-to-parallel capture stages. It accepts words through a valid/ready handshake and supports gapless back-to-back frames.

## Interface
- WIDTH, 4: parallel word width, bits per frame; legal range WIDTH >= 2.
- MSB_FIRST, 1: 1 = din[WIDTH-1] is sent first; 0 = din[0] is sent first.

- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- din  input  WIDTH  parallel word to transmit.
- din_valid  input  1  din holds a word to send.
- din_ready  output  1  block can capture din on this edge.
- sout  output  1  serial data bit; 0 when sout_valid = 0.
- sout_valid  output  1  sout carries a frame bit this cycle.
- frame_start  output  1  high for the first bit of each frame.
- frame_end  output  1  high for the last bit of each frame.

## Operation
- FSM states:
  - IDLE: no frame in progress.
  - SHIFT: a frame is being sent.
- Datapath: shift register shreg[WIDTH-1:0]; bit counter cnt with width $clog2(WIDTH).
- Accept = din_valid && din_ready, sampled at the rising edge.
- din_ready:
  - 1 in IDLE.
  - 1 in SHIFT when cnt == WIDTH-1, i.e. during the last bit.
  - 0 otherwise.
- Accept from IDLE, or on the last bit: shreg <= din, cnt <= 0, state <= SHIFT.
- In SHIFT with no accept:
  - If cnt < WIDTH-1: cnt increments; shreg shifts left when MSB_FIRST = 1, right when MSB_FIRST = 0; the vacated bit fills with 0.
  - If cnt == WIDTH-1: state <= IDLE.
- Output decode (state/shreg/cnt registers only; no combinational path from din or din_valid to any output except din_ready):
  - sout = shreg[WIDTH-1] when MSB_FIRST = 1, shreg[0] when MSB_FIRST = 0, gated by SHIFT.
  - sout_valid = (state == SHIFT).
  - frame_start = SHIFT && cnt == 0.
  - frame_end = SHIFT && cnt == WIDTH-1.
- din is sampled only at accept. Changes to din or din_valid mid-frame have no effect on the frame in flight.
- A held din_valid across the last bit gives an accept on that edge: the next frame starts the following cycle with no idle gap.
- din_valid deasserted on the last bit: the block returns to IDLE and sout_valid drops the next cycle.

## Timing
- Reset values (rst_n low, asynchronous):
  - state = IDLE, shreg = 0, cnt = 0.
  - sout = 0, sout_valid = 0, frame_start = 0, frame_end = 0.
  - din_ready = 1; no capture can occur while rst_n is low.
- Latency: word accepted at edge k; bit 0 appears in the cycle after edge k; bit WIDTH-1 appears in the cycle after edge k+WIDTH-1.
- Throughput: one word per WIDTH cycles when din_valid is held continuously.
- Reset mid-frame: the frame is aborted and outputs go to reset values immediately. After rst_n deasserts, the block is in IDLE; no partial frame resumes.
- Reset release is synchronised by the system; the first accept can occur on the first rising edge with rst_n high.

## Structure
- Package piso_pkg:
  - state typedef enum logic {IDLE, SHIFT}.
  - Localparam helper for counter width: max(1, $clog2(WIDTH)).
- Single module, no sub-module.
- Counter and shift register live in one always block with the FSM, async-reset style (posedge clk or negedge rst_n).

## Test plan
WIDTH = 4, MSB_FIRST = 1 unless stated.
- Reset: rst_n = 0 for 2 cycles -> sout, sout_valid, frame_start, frame_end all 0; din_ready = 1.
- Single word: din = 4'b0110 accepted at edge 1, then din_valid = 0 ->
  - sout = 0,1,1,0 in the 4 following cycles.
  - frame_start on the first bit, frame_end on the fourth.
  - sout_valid = 0 on the fifth cycle.
- Back-to-back: din_valid held with 4'b0011 then 4'b1100 (second word presented while frame_end = 1) ->
  - 8 contiguous bits 0,0,1,1,1,1,0,0 with sout_valid continuously 1.
  - frame_start on bits 1 and 5.
- Mid-frame request: during bit 2 of 4'b0101, drive din = 4'b1010 with din_valid = 1 ->
  - din_ready = 0 until bit 4; the first frame stays 0,1,0,1.
  - 4'b1010 is accepted on the bit-4 edge and sent as 1,0,1,0 immediately after.
- Reset mid-frame: pull rst_n low after 2 bits of 4'b0101 ->
  - all outputs 0 asynchronously.
  - After release: IDLE; a new word 4'b1111 is sent as four 1s with correct frame_start/frame_end.
- LSB-first: MSB_FIRST = 0, din = 4'b0011 -> sout = 1,1,0,0.
